impulse_checker: RTL and testbench
==================================

IMPULSE_CHECKER -- requirements
Module: impulse_checker

Interface
REQ-001 Parameter WIDTH, default 16, bits per real/imag component.
REQ-002 Parameter SAMP_PER_CLK, default 2, complex samples per beat.
REQ-003 Parameter FFT_LEN, default 64, samples per frame; multiple of SAMP_PER_CLK, BEATS = FFT_LEN/SAMP_PER_CLK >= 2.
REQ-004 Parameter IMPULSE_PHA, default 0, sample index of the impulse within a frame (0..FFT_LEN-1).
REQ-005 Parameter IMPULSE_VAL, default 64, expected signed real value of the impulse sample.
REQ-006 Parameter READY_MASK, default 8'hFF, 8-bit rotating backpressure pattern.
REQ-007 clk  input  1  single clock; all logic rising-edge.
REQ-008 rst_n  input  1  reset; asynchronous, active-low.
REQ-009 s_axis_tdata  input  2*SAMP_PER_CLK*WIDTH  packed complex samples.
REQ-010 s_axis_tvalid  input  1  upstream data valid.
REQ-011 s_axis_tready  output  1  checker ready.
REQ-012 s_axis_tlast  input  1  last beat of frame.
REQ-013 frame_ok_cnt  output  32  frames completed with no error.
REQ-014 frame_cnt  output  32  frames completed (correct tlast position).
REQ-015 err_cnt  output  16  total data-lane plus tlast errors, saturating.
REQ-016 data_err  output  1  one-cycle pulse, mismatch on last accepted beat.
REQ-017 tlast_err  output  1  one-cycle pulse, tlast misplaced on last accepted beat.
REQ-018 resync  output  1  high while in RESYNC state.

Function
REQ-019 Lane k (0..SAMP_PER_CLK-1) SHALL occupy tdata[2*WIDTH*(k+1)-1 : 2*WIDTH*k]; real in low WIDTH bits, imag in high WIDTH bits, both two's complement.
REQ-020 A beat SHALL be accepted only on a cycle where s_axis_tvalid and s_axis_tready are both high.
REQ-021 s_axis_tready SHALL equal READY_MASK[ptr], ptr a 3-bit counter incremented every cycle out of reset, independent of tvalid.
REQ-022 States SHALL be CHECK and RESYNC; reset state CHECK with beat counter 0.
REQ-023 In CHECK, each accepted beat at beat index b: lane k expected real = IMPULSE_VAL and imag = 0 when b*SAMP_PER_CLK+k == IMPULSE_PHA, else real = imag = 0.
REQ-024 Any lane mismatch SHALL assert data_err the cycle after acceptance and mark the current frame bad.
REQ-025 Accepted beat with b == BEATS-1 and tlast = 1: frame_cnt += 1, frame_ok_cnt += 1 if frame not bad (including this beat), beat counter -> 0, bad flag cleared.
REQ-026 Accepted beat with b < BEATS-1 and tlast = 1 (early tlast): tlast_err pulse, beat counter -> 0, bad flag cleared, no frame counted, remain CHECK.
REQ-027 Accepted beat with b == BEATS-1 and tlast = 0 (missing tlast): tlast_err pulse, transition to RESYNC, no frame counted.
REQ-028 In RESYNC, accepted beats SHALL not be data-checked; accepted beat with tlast = 1 returns to CHECK, beat counter 0, bad flag cleared.
REQ-029 data_err and tlast_err on the same beat SHALL both pulse; err_cnt SHALL increment by the number of pulses asserted (0..2), saturating at 16'hFFFF.
REQ-030 frame_cnt and frame_ok_cnt SHALL wrap modulo 2^32.
REQ-031 All outputs except s_axis_tready SHALL be registered; counters reflect a beat one cycle after its acceptance.
REQ-032 No state or counter SHALL change on cycles without acceptance (except ptr).

Reset
REQ-033 rst_n low SHALL immediately clear all counters, pulses, resync, ptr, beat counter, bad flag, and force state CHECK.
REQ-034 While rst_n low, s_axis_tready SHALL be 0; after release it follows REQ-021 starting at ptr = 0.
REQ-035 Reset asserted mid-frame SHALL discard the partial frame; the first accepted beat after release is beat 0.

Verification
REQ-036 Defaults, 10 correct frames (lane0 beat0 real = 64, rest 0, tlast on beat 31) -> frame_cnt = frame_ok_cnt = 10, err_cnt = 0.
REQ-037 READY_MASK = 8'b1010_0110, tvalid always high, 4 good frames -> accepted beats only on ready cycles, frame_ok_cnt = 4, err_cnt = 0.
REQ-038 Frame 2 beat 5 lane1 imag = 1 -> one data_err pulse, frame_cnt = 3, frame_ok_cnt = 2 after 3 frames, err_cnt = 1.
REQ-039 tlast on beat 10, then 2 good frames -> tlast_err once, frame_cnt = 2, err_cnt = 1, resync never high.
REQ-040 No tlast on beat 31, tlast on next beat, 1 good frame -> tlast_err once, resync high until that tlast accepted, frame_cnt = 1.
REQ-041 rst_n pulsed low at beat 17 of frame 3 -> all counters 0, tready 0 during reset; following good frame gives frame_ok_cnt = 1.

Source files
------------

// File: rtl/impulse_checker.sv
// impulse_checker: checks a framed complex stream against a single expected impulse per frame
module impulse_checker #(
  parameter int WIDTH = 16,
  parameter int SAMP_PER_CLK = 2,
  parameter int FFT_LEN = 64,
  parameter int IMPULSE_PHA = 0,
  parameter int IMPULSE_VAL = 64,
  parameter logic [7:0] READY_MASK = 8'hFF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [2*SAMP_PER_CLK*WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [31:0]                     frame_ok_cnt,
  output logic [31:0]                     frame_cnt,
  output logic [15:0]                     err_cnt,
  output logic                            data_err,
  output logic                            tlast_err,
  output logic                            resync
);
  localparam int BEATS = FFT_LEN / SAMP_PER_CLK;
  localparam int BW = $clog2(BEATS);
  typedef enum logic {CHECK, RESYNC} state_t;
  state_t state, state_nx;
  logic [2:0] ptr;
  logic [BW-1:0] beat, beat_nx;
  logic bad, bad_nx, mism, last, acc, de_nx, te_nx, fr_inc, ok_inc;
  logic [16:0] err_sum;
  assign s_axis_tready = rst_n & READY_MASK[ptr];
  assign acc = s_axis_tvalid & s_axis_tready;
  assign last = beat == BW'(BEATS - 1);
  assign resync = state == RESYNC;
  assign err_sum = {1'b0, err_cnt} + 17'(de_nx) + 17'(te_nx);
  // compare every lane of the current beat with the impulse expected at its sample index
  always_comb begin
    mism = 1'b0;
    for (int k = 0; k < SAMP_PER_CLK; k++)
      mism |= s_axis_tdata[2*WIDTH*k +: 2*WIDTH] !=
              {WIDTH'(0), ((int'(beat) * SAMP_PER_CLK + k == IMPULSE_PHA) ? WIDTH'(IMPULSE_VAL) : WIDTH'(0))};
  end
  // next state, frame bookkeeping and error pulses for the accepted beat
  always_comb begin
    state_nx = state;
    beat_nx = beat;
    bad_nx = bad;
    de_nx = 1'b0;
    te_nx = 1'b0;
    fr_inc = 1'b0;
    ok_inc = 1'b0;
    if (acc && state == RESYNC) begin
      if (s_axis_tlast) begin
        state_nx = CHECK;
        beat_nx = '0;
        bad_nx = 1'b0;
      end
    end else if (acc) begin
      de_nx = mism;
      te_nx = s_axis_tlast != last;
      if (s_axis_tlast) begin
        fr_inc = last;
        ok_inc = last & ~(bad | mism);
        beat_nx = '0;
        bad_nx = 1'b0;
      end else if (last) begin
        state_nx = RESYNC;
        beat_nx = '0;
        bad_nx = 1'b0;
      end else begin
        beat_nx = beat + 1'b1;
        bad_nx = bad | mism;
      end
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= CHECK;
    else state <= state_nx;
  // ready rotation, beat position, counters and registered pulses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      beat <= '0;
      bad <= 1'b0;
      data_err <= 1'b0;
      tlast_err <= 1'b0;
      frame_cnt <= '0;
      frame_ok_cnt <= '0;
      err_cnt <= '0;
    end else begin
      ptr <= ptr + 3'd1;
      beat <= beat_nx;
      bad <= bad_nx;
      data_err <= de_nx;
      tlast_err <= te_nx;
      frame_cnt <= frame_cnt + 32'(fr_inc);
      frame_ok_cnt <= frame_ok_cnt + 32'(ok_inc);
      err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
endmodule

// File: tb/tb_impulse_checker.sv
// tb_impulse_checker: directed self-checking bench with a frame-level reference model
module tb_impulse_checker;
  localparam int BEATS = 32;
  localparam logic [7:0] MASK [2] = '{8'hFF, 8'hA6};
  logic clk = 1'b0, rst_n = 1'b1;
  logic [63:0] tdata [2];
  logic tvalid [2], tlast [2], tready [2], data_err [2], tlast_err [2], resync [2];
  logic [31:0] frame_ok_cnt [2], frame_cnt [2];
  logic [15:0] err_cnt [2];
  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int pos [2], m_frames [2], m_ok [2], m_err [2], de_seen [2], te_seen [2], rs_seen [2];
  bit sync [2], bad [2], m_de [2], m_te [2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    impulse_checker #(.READY_MASK(MASK[g])) dut (
      .clk(clk), .rst_n(rst_n), .s_axis_tdata(tdata[g]), .s_axis_tvalid(tvalid[g]),
      .s_axis_tready(tready[g]), .s_axis_tlast(tlast[g]), .frame_ok_cnt(frame_ok_cnt[g]),
      .frame_cnt(frame_cnt[g]), .err_cnt(err_cnt[g]), .data_err(data_err[g]),
      .tlast_err(tlast_err[g]), .resync(resync[g]));
  end
  task automatic check(input int i, input string name, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d expected %0d at %0t", i, name, got, exp, $time);
    end
  endtask
  // the one frame every source should send: impulse at sample 0, real 64, everything else zero
  function automatic logic [63:0] want(input int p);
    want = '0;
    for (int k = 0; k < 2; k++)
      if (p * 2 + k == 0) want[32*k +: 16] = 16'd64;
  endfunction
  task automatic model_beat(input int i, input logic [63:0] d, input logic l);
    bit mis, at_end;
    if (!sync[i]) begin
      if (l) begin sync[i] = 1; pos[i] = 0; bad[i] = 0; end
      return;
    end
    mis = d != want(pos[i]);
    at_end = pos[i] == BEATS - 1;
    m_de[i] = mis;
    m_te[i] = l != at_end;
    m_err[i] = m_err[i] + int'(mis) + int'(m_te[i]);
    if (m_err[i] > 65535) m_err[i] = 65535;
    if (l) begin
      if (at_end) begin
        m_frames[i]++;
        if (!bad[i] && !mis) m_ok[i]++;
      end
      pos[i] = 0;
      bad[i] = 0;
    end else if (at_end) sync[i] = 0;
    else begin
      pos[i]++;
      bad[i] = bad[i] | mis;
    end
  endtask
  // per-cycle comparison against the model, then predict the acceptance at the next edge
  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      for (int i = 0; i < 2; i++) begin
        sync[i] = 1; pos[i] = 0; bad[i] = 0; m_frames[i] = 0; m_ok[i] = 0;
        m_err[i] = 0; m_de[i] = 0; m_te[i] = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      check(i, "tready", tready[i], rst_n ? longint'(MASK[i][cyc % 8]) : 0);
      check(i, "frame_cnt", frame_cnt[i], m_frames[i]);
      check(i, "frame_ok_cnt", frame_ok_cnt[i], m_ok[i]);
      check(i, "err_cnt", err_cnt[i], m_err[i]);
      check(i, "data_err", data_err[i], m_de[i]);
      check(i, "tlast_err", tlast_err[i], m_te[i]);
      check(i, "resync", resync[i], !sync[i]);
      de_seen[i] += int'(data_err[i]);
      te_seen[i] += int'(tlast_err[i]);
      rs_seen[i] += int'(resync[i]);
    end
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_de[i] = 0;
        m_te[i] = 0;
        if (tvalid[i] && MASK[i][cyc % 8]) model_beat(i, tdata[i], tlast[i]);
      end
      cyc++;
    end
  end
  task automatic send(input int i, input logic [63:0] d, input logic l);
    bit took = 0;
    tdata[i] = d;
    tlast[i] = l;
    tvalid[i] = 1'b1;
    for (int n = 0; n < 16 && !took; n++) begin
      @(negedge clk);
      took = tready[i];
      @(posedge clk);
      #1;
    end
    if (!took) begin
      n_chk++;
      n_fail++;
      $display("FAIL u%0d accept timeout: got no ready expected ready within 16 cycles", i);
    end
  endtask
  task automatic frame(input int i, input int n_beats, input int tl_at, input int bad_beat);
    logic [63:0] d;
    for (int b = 0; b < n_beats; b++) begin
      d = want(b);
      if (b == bad_beat) d[48] = 1'b1;
      send(i, d, b == tl_at);
    end
  endtask
  task automatic idle(input int n);
    tvalid[0] = 1'b0;
    tvalid[1] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    tvalid[0] = 1'b0;
    tvalid[1] = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check(i, "reset tready", tready[i], 0);
      check(i, "reset frame_cnt", frame_cnt[i], 0);
      check(i, "reset frame_ok_cnt", frame_ok_cnt[i], 0);
      check(i, "reset err_cnt", err_cnt[i], 0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin de_seen[i] = 0; te_seen[i] = 0; rs_seen[i] = 0; end
  endtask
  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 2; i++) begin tdata[i] = '0; tvalid[i] = 1'b0; tlast[i] = 1'b0; end
    #1 do_reset();
    repeat (10) frame(0, 32, 31, -1);
    idle(2);
    check(0, "good frame_cnt", frame_cnt[0], 10);
    check(0, "good frame_ok_cnt", frame_ok_cnt[0], 10);
    check(0, "good err_cnt", err_cnt[0], 0);
    do_reset();
    repeat (4) frame(1, 32, 31, -1);
    idle(2);
    check(1, "mask frame_cnt", frame_cnt[1], 4);
    check(1, "mask frame_ok_cnt", frame_ok_cnt[1], 4);
    check(1, "mask err_cnt", err_cnt[1], 0);
    do_reset();
    frame(0, 32, 31, -1);
    frame(0, 32, 31, 5);
    frame(0, 32, 31, -1);
    idle(2);
    check(0, "data data_err pulses", de_seen[0], 1);
    check(0, "data frame_cnt", frame_cnt[0], 3);
    check(0, "data frame_ok_cnt", frame_ok_cnt[0], 2);
    check(0, "data err_cnt", err_cnt[0], 1);
    do_reset();
    frame(0, 11, 10, -1);
    repeat (2) frame(0, 32, 31, -1);
    idle(2);
    check(0, "early tlast_err pulses", te_seen[0], 1);
    check(0, "early frame_cnt", frame_cnt[0], 2);
    check(0, "early err_cnt", err_cnt[0], 1);
    check(0, "early resync cycles", rs_seen[0], 0);
    do_reset();
    frame(0, 32, -1, -1);
    idle(1);
    check(0, "missing resync high", resync[0], 1);
    frame(0, 1, 0, -1);
    frame(0, 32, 31, -1);
    idle(2);
    check(0, "missing tlast_err pulses", te_seen[0], 1);
    check(0, "missing frame_cnt", frame_cnt[0], 1);
    check(0, "missing err_cnt", err_cnt[0], 1);
    check(0, "missing resync low", resync[0], 0);
    do_reset();
    repeat (2) frame(0, 32, 31, -1);
    frame(0, 17, -1, -1);
    check(0, "pre-reset frame_cnt", frame_cnt[0], 2);
    do_reset();
    frame(0, 32, 31, -1);
    idle(2);
    check(0, "after reset frame_ok_cnt", frame_ok_cnt[0], 1);
    check(0, "after reset frame_cnt", frame_cnt[0], 1);
    do_reset();
    for (int n = 0; n < 32770; n++) send(0, 64'd0, 1'b1);
    idle(2);
    check(0, "sat err_cnt", err_cnt[0], 16'hFFFF);
    check(0, "sat data_err pulses", de_seen[0], 32770);
    check(0, "sat tlast_err pulses", te_seen[0], 32770);
    check(0, "sat frame_cnt", frame_cnt[0], 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
